// File: rtl/ikaopm_acc_mc.sv
// ikaopm_acc_mc: per-channel frame accumulator with saturated parallel output
// and a linear / 10.3 floating-point serial stream for external DACs.
module ikaopm_acc_mc #(
  parameter int CH_NUM = 2,
  parameter int IN_W   = 14,
  parameter int ACC_W  = 18,
  parameter int OUT_W  = 16
) (
  input  logic                    i_EMUCLK,
  input  logic                    i_MRST,
  input  logic                    i_CEN_n,
  input  logic                    i_FRAME_SYNC,
  input  logic                    i_SAMPLE_VALID,
  input  logic [IN_W-1:0]         i_SAMPLE,
  input  logic [CH_NUM-1:0]       i_CH_EN,
  input  logic                    i_MODE,
  output logic [CH_NUM*OUT_W-1:0] o_PO,
  output logic                    o_PO_VALID,
  output logic                    o_SO,
  output logic                    o_SYNC,
  output logic                    o_BUSY,
  output logic                    o_OVERRUN
);
  localparam int CW = CH_NUM > 1 ? $clog2(CH_NUM) : 1;
  localparam int BW = $clog2(OUT_W);
  localparam int SW = ACC_W > OUT_W ? ACC_W : OUT_W;
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state_q, state_d;
  logic [ACC_W-1:0] acc_q [CH_NUM];
  logic [ACC_W-1:0] acc_d [CH_NUM];
  logic [CH_NUM*OUT_W-1:0] po_q, po_d;
  logic po_valid_q, po_valid_d, ovr_q, ovr_d, mode_q, mode_d;
  logic [CW-1:0] ch_q, ch_d;
  logic [BW-1:0] bit_q, bit_d;
  logic en, last_bit, last, run;
  logic [ACC_W-1:0] ext, fin;
  logic [SW-1:0] finx;
  logic [SW-OUT_W:0] hi;
  logic [OUT_W-1:0] po_ch;
  logic [15:0] v, fword;
  logic [2:0] k, e;
  assign en = ~i_CEN_n;
  always_comb begin : accum
    ext = ACC_W'($signed(i_SAMPLE));
    po_d = po_q;
    po_valid_d = en ? i_FRAME_SYNC : po_valid_q;
    fin = '0;
    finx = '0;
    hi = '0;
    for (int n = 0; n < CH_NUM; n++) begin
      fin = acc_q[n] + ((i_SAMPLE_VALID && i_CH_EN[n]) ? ext : '0);
      acc_d[n] = !en ? acc_q[n] : i_FRAME_SYNC ? '0 : fin;
      // bits above the output sign must all agree for the sum to fit
      finx = SW'($signed(fin));
      hi = finx[SW-1:OUT_W-1];
      if (en && i_FRAME_SYNC)
        po_d[n*OUT_W +: OUT_W] = (&hi || !(|hi)) ? finx[OUT_W-1:0]
                               : {finx[SW-1], {(OUT_W-1){~finx[SW-1]}}};
    end
  end
  always_comb begin : ser
    po_ch = po_q[ch_q*OUT_W +: OUT_W];
    v = po_ch[OUT_W-1 -: 16];
    k = '0;
    run = 1'b1;
    for (int i = 14; i >= 9; i--) begin
      run = run && (v[i] == v[15]);
      k = k + {2'b0, run};
    end
    e = 3'd7 - k;
    fword = {3'b0, e, 10'(v >> (e - 3'd1))};
    last_bit = bit_q == (mode_q ? BW'(15) : BW'(OUT_W - 1));
    last = state_q == SHIFT && last_bit && ch_q == CW'(CH_NUM - 1);
    state_d = state_q;
    ch_d = ch_q;
    bit_d = bit_q;
    mode_d = mode_q;
    ovr_d = en ? (i_FRAME_SYNC && state_q == SHIFT && !last) : ovr_q;
    if (en && po_valid_q) begin
      state_d = SHIFT;
      ch_d = '0;
      bit_d = '0;
      mode_d = i_MODE;
    end else if (en && state_q == SHIFT) begin
      state_d = (i_FRAME_SYNC || last) ? IDLE : SHIFT;
      bit_d = last_bit ? '0 : bit_q + 1'b1;
      ch_d = last_bit ? ch_q + 1'b1 : ch_q;
    end
    o_BUSY = state_q == SHIFT;
    o_SYNC = o_BUSY && bit_q == '0;
    o_SO = o_BUSY && (mode_q ? fword[bit_q[3:0]] : po_ch[bit_q]);
  end
  always_ff @(posedge i_EMUCLK or posedge i_MRST) begin
    if (i_MRST) begin
      acc_q <= '{default: '0};
      po_q <= '0;
      po_valid_q <= 1'b0;
      ovr_q <= 1'b0;
      mode_q <= 1'b0;
      state_q <= IDLE;
      ch_q <= '0;
      bit_q <= '0;
    end else begin
      acc_q <= acc_d;
      po_q <= po_d;
      po_valid_q <= po_valid_d;
      ovr_q <= ovr_d;
      mode_q <= mode_d;
      state_q <= state_d;
      ch_q <= ch_d;
      bit_q <= bit_d;
    end
  end
  assign o_PO = po_q;
  assign o_PO_VALID = po_valid_q;
  assign o_OVERRUN = ovr_q;
endmodule

// File: tb/tb_ikaopm_acc_mc.sv
// tb_ikaopm_acc_mc: table-driven accumulate/saturate vectors plus serial-stream sequences.
module tb_ikaopm_acc_mc;
  typedef struct {
    logic v;
    logic [13:0] s;
    logic [1:0] c;
    logic f;
    logic pv;
    logic [31:0] po;
  } vec_t;
  logic clk = 1'b0;
  logic rst, cen_n, fs, sv, mode;
  logic [13:0] smp;
  logic [1:0] chen;
  logic [31:0] po;
  logic pv, so, sync, busy, ovr;
  int n_chk = 0, n_fail = 0;
  logic [31:0] so_w, sy_w, cur_po;
  logic bz_ok, frz_ok;
  logic [2:0] saved;
  vec_t tbl[$];

  ikaopm_acc_mc #(.CH_NUM(2), .IN_W(14), .ACC_W(18), .OUT_W(16)) dut (
    .i_EMUCLK(clk), .i_MRST(rst), .i_CEN_n(cen_n), .i_FRAME_SYNC(fs),
    .i_SAMPLE_VALID(sv), .i_SAMPLE(smp), .i_CH_EN(chen), .i_MODE(mode),
    .o_PO(po), .o_PO_VALID(pv), .o_SO(so), .o_SYNC(sync), .o_BUSY(busy),
    .o_OVERRUN(ovr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [13:0] s, input logic [1:0] c, input logic f);
    sv = v; smp = s; chen = c; fs = f;
  endtask
  task automatic idle_in();
    drive(1'b0, 14'h0, 2'b00, 1'b0);
  endtask
  task automatic put(input logic v, input logic [13:0] s, input logic [1:0] c, input logic f,
                     input logic [31:0] res);
    vec_t r;
    if (f) cur_po = res;
    r.v = v; r.s = s; r.c = c; r.f = f; r.pv = f; r.po = cur_po;
    tbl.push_back(r);
  endtask
  task automatic capture(input int first, input int n);
    for (int b = first; b < first + n; b++) begin
      step();
      so_w[b] = so;
      sy_w[b] = sync;
      if (!busy) bz_ok = 1'b0;
    end
  endtask
  task automatic wait_idle();
    int c = 0;
    while (busy && c < 200) begin
      step();
      c++;
    end
    chk("idle_timeout", busy, 0);
  endtask
  task automatic frame_5ffd();
    drive(1'b1, 14'h1FFF, 2'b01, 1'b0);
    step();
    step();
    fs = 1'b1;
    step();
    idle_in();
  endtask
  task automatic clr_cap();
    so_w = '0; sy_w = '0; bz_ok = 1'b1;
  endtask

  initial begin
    cur_po = '0;
    cen_n = 1'b0;
    mode = 1'b0;
    idle_in();
    rst = 1'b1;
    #2;
    chk("reset_state", {po, pv, so, sync, busy, ovr}, 0);
    step();
    step();
    rst = 1'b0;

    repeat (2) put(1, 14'h1FFF, 2'b01, 0, 0);
    put(1, 14'h1FFF, 2'b01, 1, 32'h0000_5FFD);
    repeat (5) put(1, 14'h1FFF, 2'b01, 0, 0);
    repeat (4) put(1, 14'h2000, 2'b10, 0, 0);
    put(1, 14'h2000, 2'b10, 1, 32'h8000_7FFF);
    put(1, 14'h3000, 2'b11, 0, 0);
    put(0, 14'h0100, 2'b10, 0, 0);
    put(0, 14'h0000, 2'b00, 1, 32'hF000_F000);
    put(1, 14'h0005, 2'b11, 1, 32'h0005_0005);
    repeat (16) put(1, 14'h1FFF, 2'b01, 0, 0);
    put(1, 14'h1FFF, 2'b01, 1, 32'h0000_8000);
    put(1, 14'h1FFF, 2'b11, 0, 0);
    put(1, 14'h3FFF, 2'b01, 1, 32'h1FFF_1FFE);
    repeat (4) put(1, 14'h1FFF, 2'b01, 0, 0);
    repeat (4) put(1, 14'h2000, 2'b10, 0, 0);
    put(1, 14'h0003, 2'b01, 1, 32'h8000_7FFF);
    repeat (4) put(1, 14'h2000, 2'b01, 0, 0);
    put(1, 14'h3FFF, 2'b01, 0, 0);
    repeat (4) put(1, 14'h1FFF, 2'b10, 0, 0);
    put(1, 14'h0004, 2'b10, 1, 32'h7FFF_8000);
    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].s, tbl[i].c, tbl[i].f);
      step();
      chk($sformatf("tbl%0d_pv", i), pv, tbl[i].pv);
      chk($sformatf("tbl%0d_po", i), po, tbl[i].po);
    end
    idle_in();
    wait_idle();

    // linear stream; i_MODE flipped mid-stream must be ignored
    frame_5ffd();
    chk("lin_pv", pv, 1);
    chk("lin_po", po, 32'h0000_5FFD);
    chk("lin_busy0", busy, 0);
    clr_cap();
    capture(0, 1);
    mode = 1'b1;
    capture(1, 31);
    chk("lin_word", so_w, 32'h0000_5FFD);
    chk("lin_sync", sy_w, 32'h0001_0001);
    chk("lin_busy", bz_ok, 1);
    step();
    chk("lin_end", {busy, so, sync}, 0);

    // float streams
    drive(1'b1, 14'h0123, 2'b01, 1'b0);
    step();
    drive(1'b1, 14'h1000, 2'b10, 1'b0);
    repeat (3) step();
    fs = 1'b1;
    step();
    idle_in();
    chk("flt1_po", po, 32'h4000_0123);
    clr_cap();
    capture(0, 32);
    chk("flt1_word", so_w, 32'h1D00_0523);
    chk("flt1_sync", sy_w, 32'h0001_0001);
    step();
    drive(1'b1, 14'h3FFF, 2'b01, 1'b0);
    step();
    drive(1'b1, 14'h2000, 2'b10, 1'b0);
    repeat (4) step();
    fs = 1'b1;
    step();
    idle_in();
    chk("flt2_po", po, 32'h8000_FFFF);
    clr_cap();
    capture(0, 32);
    chk("flt2_word", so_w, 32'h1E00_07FF);
    chk("flt2_busy", bz_ok, 1);
    step();
    mode = 1'b0;

    // overrun: frame close while bit 8 is on the wire
    frame_5ffd();
    clr_cap();
    capture(0, 9);
    chk("ovr_bits", so_w[8:0], 9'h1FD);
    drive(1'b1, 14'h0007, 2'b11, 1'b1);
    step();
    idle_in();
    chk("ovr_pulse", {pv, ovr, busy, so}, 4'b1100);
    chk("ovr_po", po, 32'h0007_0007);
    step();
    chk("ovr_restart", {pv, ovr, busy, sync, so}, 5'b00111);
    clr_cap();
    so_w[0] = so;
    sy_w[0] = sync;
    capture(1, 31);
    chk("ovr_word", so_w, 32'h0007_0007);
    chk("ovr_sync", sy_w, 32'h0001_0001);
    step();

    // clock enable: pulse held, sample ignored, stream frozen then resumed
    frame_5ffd();
    cen_n = 1'b1;
    drive(1'b1, 14'h0100, 2'b11, 1'b0);
    frz_ok = 1'b1;
    repeat (3) begin
      step();
      if (pv !== 1'b1 || busy !== 1'b0) frz_ok = 1'b0;
    end
    chk("cen_pv_hold", frz_ok, 1);
    idle_in();
    cen_n = 1'b0;
    clr_cap();
    capture(0, 5);
    saved = {so, sync, busy};
    cen_n = 1'b1;
    frz_ok = 1'b1;
    repeat (5) begin
      step();
      if ({so, sync, busy} !== saved) frz_ok = 1'b0;
    end
    chk("cen_freeze", frz_ok, 1);
    cen_n = 1'b0;
    capture(5, 27);
    chk("cen_word", so_w, 32'h0000_5FFD);
    chk("cen_sync", sy_w, 32'h0001_0001);
    step();
    drive(1'b1, 14'h0001, 2'b11, 1'b1);
    step();
    idle_in();
    chk("cen_acc", po, 32'h0001_0001);
    wait_idle();

    // asynchronous reset mid-stream with a partly filled accumulator
    frame_5ffd();
    clr_cap();
    capture(0, 5);
    drive(1'b1, 14'h0100, 2'b01, 1'b0);
    step();
    idle_in();
    #2 rst = 1'b1;
    #1 chk("rst_async", {po, pv, so, sync, busy, ovr}, 0);
    step();
    rst = 1'b0;
    step();
    chk("rst_quiet", {busy, pv, so, sync, ovr}, 0);
    drive(1'b1, 14'h0002, 2'b11, 1'b1);
    step();
    idle_in();
    chk("rst_po", {pv, po}, {1'b1, 32'h0002_0002});
    clr_cap();
    capture(0, 32);
    chk("rst_word", so_w, 32'h0002_0002);
    chk("rst_sync", sy_w, 32'h0001_0001);
    step();
    chk("rst_end", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
